// File: rtl/memory_stage_pkg.sv
// Shared constants for the memory stage: memory operation codes, FSM state
// encoding, TRUE/FALSE and small decode helpers for lane handling.
package memory_stage_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Memory operation codes; 9..15 decode as MEM_NONE.
    localparam logic [3:0] MEM_NONE = 4'd0;
    localparam logic [3:0] MEM_LB   = 4'd1;
    localparam logic [3:0] MEM_LH   = 4'd2;
    localparam logic [3:0] MEM_LW   = 4'd3;
    localparam logic [3:0] MEM_LBU  = 4'd4;
    localparam logic [3:0] MEM_LHU  = 4'd5;
    localparam logic [3:0] MEM_SB   = 4'd6;
    localparam logic [3:0] MEM_SH   = 4'd7;
    localparam logic [3:0] MEM_SW   = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    // Lane actually used for an access: halfword ops drop addr[0], word ops
    // drop addr[1:0], byte ops keep the full lane.
    function automatic logic [1:0] aligned_lane(input logic [3:0] op, input logic [1:0] lane);
        logic [1:0] res;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: res = {lane[1], 1'b0};
            MEM_LW, MEM_SW:          res = 2'b00;
            default:                 res = lane;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic res;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: res = lane[0];
            MEM_LW, MEM_SW:          res = (lane != 2'b00);
            default:                 res = FALSE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/memory_stage_mem_align.sv
// mem_align: purely combinational byte-lane steering. Produces store strobes
// and replicated store data, and the sign/zero-extended load result.
module mem_align
    import memory_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_result
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Select the addressed byte and halfword out of the read word
    always_comb begin
        rd_byte = rdata[7:0];
        case (lane)
            2'd0: rd_byte = rdata[7:0];
            2'd1: rd_byte = rdata[15:8];
            2'd2: rd_byte = rdata[23:16];
            2'd3: rd_byte = rdata[31:24];
            default: rd_byte = rdata[7:0];
        endcase
        rd_half = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    // Decode the op into strobes, write data and formatted load data
    always_comb begin
        wstrb       = 4'b0000;
        wdata       = 32'h0;
        load_result = rdata;
        case (op)
            MEM_LB:  load_result = {{24{rd_byte[7]}}, rd_byte};
            MEM_LBU: load_result = {24'h0, rd_byte};
            MEM_LH:  load_result = {{16{rd_half[15]}}, rd_half};
            MEM_LHU: load_result = {16'h0, rd_half};
            MEM_LW:  load_result = rdata;
            MEM_SB: begin
                wstrb = 4'b0001 << lane;
                wdata = {4{store_data[7:0]}};
            end
            MEM_SH: begin
                wstrb = 4'b0011 << lane;
                wdata = {2{store_data[15:0]}};
            end
            MEM_SW: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage ahead of writeback. Non-memory instructions
// pass through in one cycle; loads/stores go over a single-outstanding
// req/ack data port while stall holds upstream.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (trap on misaligned accesses
// instead of silently clearing the offending address bits).
//
// Data-port handshake: dmem_req rises the cycle after an op is accepted and,
// together with dmem_we/addr/wdata/wstrb, holds stable until the single-cycle
// dmem_ack pulse (or a timeout); dmem_rdata is sampled only in that ack cycle,
// and an ack arriving while no request is outstanding is ignored.
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  mem_op,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        is_dest_special,
    input  logic [4:0]  dest_register,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_enable,
    output logic        wb_is_dest_special,
    output logic [4:0]  wb_dest_register,
    output logic [31:0] wb_result,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_trap,
`endif
    output logic        bus_error
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state;
    logic [7:0] count;
    logic [3:0] op_q;
    logic [1:0] lane_q;
    logic [4:0] dest_q;
    logic       special_q;

    logic [3:0]  in_op;
    logic [1:0]  in_lane;
    logic        in_misaligned;
    logic [3:0]  align_op;
    logic [1:0]  align_lane;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic [31:0] align_load;

    assign in_op   = is_mem_op(mem_op) ? mem_op : MEM_NONE;
    assign in_lane = aligned_lane(in_op, alu_result[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    assign in_misaligned = is_misaligned(in_op, alu_result[1:0]);
`else
    assign in_misaligned = FALSE;
`endif

    // The aligner serves the incoming op when idle and the latched op in WAIT
    assign align_op   = (state == ST_WAIT) ? op_q   : in_op;
    assign align_lane = (state == ST_WAIT) ? lane_q : in_lane;

    mem_align u_align (
        .op          (align_op),
        .lane        (align_lane),
        .store_data  (store_data),
        .rdata       (dmem_rdata),
        .wstrb       (align_wstrb),
        .wdata       (align_wdata),
        .load_result (align_load)
    );

    assign stall     = (state == ST_WAIT);
    assign bus_error = (state == ST_WAIT) && !dmem_ack && (count == TIMEOUT_LAST);

    // Stage FSM, timeout counter, data-port and writeback registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            count              <= 8'h0;
            op_q               <= MEM_NONE;
            lane_q             <= 2'b00;
            dest_q             <= 5'h0;
            special_q          <= FALSE;
            dmem_req           <= FALSE;
            dmem_we            <= FALSE;
            dmem_addr          <= 32'h0;
            dmem_wdata         <= 32'h0;
            dmem_wstrb         <= 4'b0000;
            wb_enable          <= FALSE;
            wb_is_dest_special <= FALSE;
            wb_dest_register   <= 5'h0;
            wb_result          <= 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap      <= FALSE;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_trap <= FALSE;
`endif
            case (state)
                ST_IDLE: begin
                    if (!enable) begin
                        wb_enable <= FALSE;
                    end else if (in_op == MEM_NONE) begin
                        wb_enable          <= TRUE;
                        wb_is_dest_special <= is_dest_special;
                        wb_dest_register   <= dest_register;
                        wb_result          <= alu_result;
                    end else if (in_misaligned) begin
                        wb_enable <= FALSE;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_trap <= TRUE;
`endif
                    end else begin
                        op_q       <= in_op;
                        lane_q     <= in_lane;
                        dest_q     <= dest_register;
                        special_q  <= is_dest_special;
                        dmem_req   <= TRUE;
                        dmem_we    <= is_store(in_op);
                        dmem_addr  <= {alu_result[31:2], 2'b00};
                        dmem_wdata <= align_wdata;
                        dmem_wstrb <= align_wstrb;
                        wb_enable  <= FALSE;
                        count      <= 8'h0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack) begin
                        dmem_req   <= FALSE;
                        dmem_we    <= FALSE;
                        dmem_wstrb <= 4'b0000;
                        state      <= ST_IDLE;
                        if (is_store(op_q)) begin
                            wb_enable <= FALSE;
                        end else begin
                            wb_enable          <= TRUE;
                            wb_result          <= align_load;
                            wb_dest_register   <= dest_q;
                            wb_is_dest_special <= special_q;
                        end
                    end else if (count == TIMEOUT_LAST) begin
                        dmem_req   <= FALSE;
                        dmem_we    <= FALSE;
                        dmem_wstrb <= 4'b0000;
                        wb_enable  <= FALSE;
                        state      <= ST_IDLE;
                    end else begin
                        count     <= count + 8'd1;
                        wb_enable <= FALSE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage (built with MEM_TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_memory_stage;
    import memory_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        enable;
    logic [3:0]  mem_op;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        is_dest_special;
    logic [4:0]  dest_register;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_enable;
    logic        wb_is_dest_special;
    logic [4:0]  wb_dest_register;
    logic [31:0] wb_result;
    logic        bus_error;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    memory_stage #(.MEM_TIMEOUT(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .mem_op             (mem_op),
        .alu_result         (alu_result),
        .store_data         (store_data),
        .is_dest_special    (is_dest_special),
        .dest_register      (dest_register),
        .stall              (stall),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_wstrb         (dmem_wstrb),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .wb_enable          (wb_enable),
        .wb_is_dest_special (wb_is_dest_special),
        .wb_dest_register   (wb_dest_register),
        .wb_result          (wb_result),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_trap      (misalign_trap),
`endif
        .bus_error          (bus_error)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Compare the writeback result of a completed load against the queue head
    task automatic check_load_wb(input string name);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no expected entry expected one", name);
        end else begin
            exp = exp_q.pop_front();
            check({name, "_en"}, 32'(wb_enable), 32'h1);
            check({name, "_res"}, wb_result, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        enable          = 1'b0;
        mem_op          = MEM_NONE;
        alu_result      = 32'h0;
        store_data      = 32'h0;
        is_dest_special = 1'b0;
        dest_register   = 5'h0;
        dmem_ack        = 1'b0;
        dmem_rdata      = 32'h0;
    endtask

    // Issue one memory op, ack it in WAIT cycle ack_at, return to the cycle
    // after the ack edge. Captures the port values seen in WAIT cycle 1.
    task automatic mem_access(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic [4:0] dest,
                              input int ack_at, input logic [31:0] rdata,
                              output int stall_cycles, output logic [31:0] got_addr,
                              output logic [3:0] got_wstrb, output logic [31:0] got_wdata,
                              output logic got_we, output logic held_ok);
        enable        = 1'b1;
        mem_op        = op;
        alu_result    = addr;
        store_data    = sdata;
        dest_register = dest;
        @(negedge clk);
        enable       = 1'b0;
        stall_cycles = 0;
        held_ok      = 1'b1;
        got_addr     = dmem_addr;
        got_wstrb    = dmem_wstrb;
        got_wdata    = dmem_wdata;
        got_we       = dmem_we;
        for (int c = 1; c <= ack_at; c++) begin
            if (stall) stall_cycles++;
            if (!dmem_req || dmem_addr !== got_addr || dmem_wstrb !== got_wstrb ||
                dmem_wdata !== got_wdata || dmem_we !== got_we) held_ok = 1'b0;
            if (c == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(negedge clk);
        end
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic [3:0]  op;
        logic [31:0] alu;
        logic        sp;
        logic [4:0]  dest;
        logic        exp_en;
        logic [31:0] exp_res;
        logic [4:0]  exp_dest;
        logic        exp_sp;
    } vec_t;

    vec_t vecs[5];

    int          st_cyc;
    logic [31:0] g_addr;
    logic [3:0]  g_wstrb;
    logic [31:0] g_wdata;
    logic        g_we;
    logic        g_held;
    int          req_cycles;
    int          err_at;

    initial begin
        vecs[0] = '{1'b1, 4'd0,  32'h12345678, 1'b0, 5'd5,  1'b1, 32'h12345678, 5'd5,  1'b0};
        vecs[1] = '{1'b1, 4'd0,  32'hDEADBEEF, 1'b1, 5'd31, 1'b1, 32'hDEADBEEF, 5'd31, 1'b1};
        vecs[2] = '{1'b0, 4'd0,  32'h11111111, 1'b0, 5'd3,  1'b0, 32'hDEADBEEF, 5'd31, 1'b1};
        vecs[3] = '{1'b1, 4'd9,  32'h0000ABCD, 1'b0, 5'd7,  1'b1, 32'h0000ABCD, 5'd7,  1'b0};
        vecs[4] = '{1'b1, 4'd15, 32'hFFFFFFFF, 1'b0, 5'd0,  1'b1, 32'hFFFFFFFF, 5'd0,  1'b0};

        drive_idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // reset values
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_we", 32'(dmem_we), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_wstrb", 32'(dmem_wstrb), 32'h0);
        check("rst_wb_en", 32'(wb_enable), 32'h0);
        check("rst_wb_res", wb_result, 32'h0);
        check("rst_wb_dest", 32'(wb_dest_register), 32'h0);
        check("rst_wb_sp", 32'(wb_is_dest_special), 32'h0);
        check("rst_berr", 32'(bus_error), 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("rst_trap", 32'(misalign_trap), 32'h0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // pass-through vectors, back to back
        for (int i = 0; i < 5; i++) begin
            enable          = vecs[i].en;
            mem_op          = vecs[i].op;
            alu_result      = vecs[i].alu;
            is_dest_special = vecs[i].sp;
            dest_register   = vecs[i].dest;
            @(negedge clk);
            check($sformatf("v%0d_wb_en", i), 32'(wb_enable), 32'(vecs[i].exp_en));
            check($sformatf("v%0d_wb_res", i), wb_result, vecs[i].exp_res);
            check($sformatf("v%0d_wb_dest", i), 32'(wb_dest_register), 32'(vecs[i].exp_dest));
            check($sformatf("v%0d_wb_sp", i), 32'(wb_is_dest_special), 32'(vecs[i].exp_sp));
            check($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
            check($sformatf("v%0d_req", i), 32'(dmem_req), 32'h0);
        end
        drive_idle();
        @(negedge clk);
        check("idle_wb_en", 32'(wb_enable), 32'h0);

        // LB at 0x1003, ack in the third WAIT cycle
        exp_q.push_back(32'hFFFFFF80);
        mem_access(MEM_LB, 32'h00001003, 32'h0, 5'd9, 3, 32'h80FFFFFF,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check("lb_addr", g_addr, 32'h00001000);
        check("lb_wstrb", 32'(g_wstrb), 32'h0);
        check("lb_we", 32'(g_we), 32'h0);
        check("lb_held", 32'(g_held), 32'h1);
        check("lb_stall_cycles", 32'(st_cyc), 32'd3);
        check("lb_stall_after", 32'(stall), 32'h0);
        check_load_wb("lb");
        check("lb_dest", 32'(wb_dest_register), 32'd9);

        // LBU on the same access
        exp_q.push_back(32'h00000080);
        mem_access(MEM_LBU, 32'h00001003, 32'h0, 5'd10, 3, 32'h80FFFFFF,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check("lbu_stall_cycles", 32'(st_cyc), 32'd3);
        check_load_wb("lbu");

        // LH / LHU upper halfword, minimum latency (ack in first WAIT cycle)
        exp_q.push_back(32'hFFFF8001);
        mem_access(MEM_LH, 32'h00001002, 32'h0, 5'd11, 1, 32'h80011234,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check_load_wb("lh");
        exp_q.push_back(32'h00008001);
        mem_access(MEM_LHU, 32'h00001002, 32'h0, 5'd12, 1, 32'h80011234,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check_load_wb("lhu");
        @(negedge clk);
        check("lhu_wb_en_drop", 32'(wb_enable), 32'h0);

        // SH at 0x2002
        mem_access(MEM_SH, 32'h00002002, 32'hAAAABEEF, 5'd1, 2, 32'h0,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check("sh_addr", g_addr, 32'h00002000);
        check("sh_wstrb", 32'(g_wstrb), 32'hC);
        check("sh_wdata", g_wdata, 32'hBEEFBEEF);
        check("sh_we", 32'(g_we), 32'h1);
        check("sh_held", 32'(g_held), 32'h1);
        check("sh_wb_en", 32'(wb_enable), 32'h0);
        @(negedge clk);
        check("sh_wb_en2", 32'(wb_enable), 32'h0);

        // SB lane 1, SW
        mem_access(MEM_SB, 32'h00001001, 32'h12345678, 5'd1, 1, 32'h0,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check("sb_wstrb", 32'(g_wstrb), 32'h2);
        check("sb_wdata", g_wdata, 32'h78787878);
        mem_access(MEM_SW, 32'h00000040, 32'hCAFEF00D, 5'd1, 1, 32'h0,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check("sw_wstrb", 32'(g_wstrb), 32'hF);
        check("sw_wdata", g_wdata, 32'hCAFEF00D);

        // misaligned LW at 0x3001
`ifdef MEM_MISALIGN_TRAP_EN
        enable     = 1'b1;
        mem_op     = MEM_LW;
        alu_result = 32'h00003001;
        @(negedge clk);
        enable = 1'b0;
        check("mis_trap", 32'(misalign_trap), 32'h1);
        check("mis_req", 32'(dmem_req), 32'h0);
        check("mis_stall", 32'(stall), 32'h0);
        check("mis_wb_en", 32'(wb_enable), 32'h0);
        @(negedge clk);
        check("mis_trap_pulse", 32'(misalign_trap), 32'h0);
`else
        exp_q.push_back(32'hCAFEBABE);
        mem_access(MEM_LW, 32'h00003001, 32'h0, 5'd13, 2, 32'hCAFEBABE,
                   st_cyc, g_addr, g_wstrb, g_wdata, g_we, g_held);
        check("lw_mis_addr", g_addr, 32'h00003000);
        check_load_wb("lw_mis");
`endif

        // timeout: no ack, bus_error in the fourth request cycle
        enable     = 1'b1;
        mem_op     = MEM_LW;
        alu_result = 32'h00000080;
        @(negedge clk);
        enable     = 1'b0;
        req_cycles = 0;
        err_at     = 0;
        while (dmem_req && req_cycles < 20) begin
            req_cycles++;
            if (bus_error && err_at == 0) err_at = req_cycles;
            @(negedge clk);
        end
        check("to_req_cycles", 32'(req_cycles), 32'd4);
        check("to_err_cycle", 32'(err_at), 32'd4);
        check("to_berr_after", 32'(bus_error), 32'h0);
        check("to_stall_after", 32'(stall), 32'h0);
        check("to_wb_en", 32'(wb_enable), 32'h0);

        // reset in WAIT, then a stray ack after release
        enable     = 1'b1;
        mem_op     = MEM_LW;
        alu_result = 32'h00000100;
        @(negedge clk);
        enable = 1'b0;
        check("rw_req_before", 32'(dmem_req), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rw_req", 32'(dmem_req), 32'h0);
        check("rw_stall", 32'(stall), 32'h0);
        check("rw_addr", dmem_addr, 32'h0);
        check("rw_wb_en", 32'(wb_enable), 32'h0);
        check("rw_wb_res", wb_result, 32'h0);
        @(negedge clk);
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55555555;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rw_no_wb", 32'(wb_enable), 32'h0);
        check("rw_no_res", wb_result, 32'h0);
        @(negedge clk);
        check("rw_no_wb2", 32'(wb_enable), 32'h0);
        check("rw_idle", 32'(stall), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
